// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first, with a one-byte holding register.
// Bit timing comes from a x16 baud tick produced by pulse_gen.

module pulse_gen #(
    parameter int acc_width = 1,
    parameter int acc_incr  = 2
) (
    input  logic i_clk,
    output logic o_pulse
);

    localparam logic [acc_width:0] INCR = (acc_width + 1)'(acc_incr);

    logic [acc_width-1:0] acc;

    // Free-running phase accumulator; the carry out is the tick.
    always_ff @(posedge i_clk) begin
        {o_pulse, acc} <= {1'b0, acc} + INCR;
    end

endmodule

module uart_tx #(
    parameter int baud_acc_width = 1,
    parameter int baud_acc_incr  = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_byte,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t     state;
    logic       baud_x16;
    logic       hold_full;
    logic [7:0] hold_byte;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic [3:0] tick_cnt;
    logic       accept;
    logic       bit_end;

    pulse_gen #(
        .acc_width (baud_acc_width),
        .acc_incr  (baud_acc_incr)
    ) u_baud (
        .i_clk   (i_clk),
        .o_pulse (baud_x16)
    );

    assign o_ready = !hold_full;
    assign o_busy  = (state != S_IDLE);
    assign accept  = i_valid && !hold_full;
    assign bit_end = baud_x16 && (tick_cnt == 4'd15);

    // Holding register plus the frame sequencer, sharing hold_full.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_IDLE;
            o_tx      <= 1'b1;
            hold_full <= 1'b0;
            hold_byte <= 8'd0;
            shift     <= 8'd0;
            bit_idx   <= 3'd0;
            tick_cnt  <= 4'd0;
        end else begin
            if (accept) begin
                hold_byte <= i_byte;
                hold_full <= 1'b1;
            end
            if (baud_x16 && state != S_IDLE) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
            unique case (state)
                S_IDLE: begin
                    o_tx <= 1'b1;
                    if (baud_x16 && hold_full) begin
                        shift     <= hold_byte;
                        hold_full <= 1'b0;
                        o_tx      <= 1'b0;
                        tick_cnt  <= 4'd0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        o_tx    <= shift[0];
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            o_tx  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            shift   <= shift >> 1;
                            o_tx    <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (hold_full) begin
                            shift     <= hold_byte;
                            hold_full <= 1'b0;
                            o_tx      <= 1'b0;
                            state     <= S_START;
                        end else begin
                            o_tx  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    o_tx  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
